boardman_bus_splitter: RTL and testbench

- Sits directly downstream of the board-manager serial interface's register-bus master port (20-bit word address, 32-bit data, en/wr/wstrb/ack).
- Decodes the top address bits to one of 2^SEL_BITS register slaves and forwards the access with registered one-hot enables.
- Returns the slave's read data and ack to the master.
- Guarantees every access completes: an absent slave or a slave that fails to ack in time is answered with an error word, so the serial link never hangs.

---
 rtl/boardman_bus_splitter_pkg.sv | 20 ++
 rtl/boardman_bus_timer.sv | 29 ++
 rtl/boardman_bus_splitter.sv | 125 ++++++++++++
 tb/tb_boardman_bus_splitter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boardman_bus_splitter_pkg.sv
// Shared widths, default error word and FSM encodings for the board-manager
// register-bus splitter.
package boardman_bus_splitter_pkg;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 20;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hBADACCE5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Counter width able to hold 0..cycles-1, never narrower than one bit.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/boardman_bus_timer.sv
// Clearable up-counter that stops at TIMEOUT_CYCLES-1 and flags terminal count.
module boardman_bus_timer
  import boardman_bus_splitter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int              CW   = timer_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/boardman_bus_splitter.sv
// Routes register-bus accesses to one of 2^SEL_BITS slaves by top address bits
// and guarantees completion with an error word on timeout or absent slave.
module boardman_bus_splitter
  import boardman_bus_splitter_pkg::*;
#(
  parameter int                       SEL_BITS       = 2,
  parameter logic [(2**SEL_BITS)-1:0] SLAVE_PRESENT  = '1,
  parameter int                       TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0]        ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADR_W-1:0]                 s_adr_i,
  input  logic [DATA_W-1:0]                s_dat_i,
  output logic [DATA_W-1:0]                s_dat_o,
  input  logic                             s_en_i,
  input  logic                             s_wr_i,
  input  logic [3:0]                       s_wstrb_i,
  output logic                             s_ack_o,
  output logic [ADR_W-SEL_BITS-1:0]        m_adr_o,
  output logic [DATA_W-1:0]                m_dat_o,
  output logic                             m_wr_o,
  output logic [3:0]                       m_wstrb_o,
  output logic [(2**SEL_BITS)-1:0]         m_en_o,
  input  logic [DATA_W*(2**SEL_BITS)-1:0]  m_dat_i,
  input  logic [(2**SEL_BITS)-1:0]         m_ack_i,
  output logic                             timeout_o,
  output logic [7:0]                       err_count_o
);

  localparam int NSLV   = 2**SEL_BITS;
  localparam int LADR_W = ADR_W - SEL_BITS;

  logic [1:0]          state;
  logic [SEL_BITS-1:0] sel;
  logic [SEL_BITS-1:0] req_sel;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_dat;
  logic                tmr_done;
  logic                err_take;

  assign req_sel = s_adr_i[ADR_W-1 -: SEL_BITS];
  assign sel_ack = m_ack_i[sel];
  assign sel_dat = m_dat_i[sel*DATA_W +: DATA_W];

  // An ack on the limit cycle takes priority over the timeout.
  assign err_take = (state == ST_ERR) ||
                    ((state == ST_WAIT) && !sel_ack && tmr_done);

  boardman_bus_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ST_WAIT),
    .enable (state == ST_WAIT),
    .done   (tmr_done)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel         <= '0;
      s_dat_o     <= '0;
      s_ack_o     <= 1'b0;
      m_adr_o     <= '0;
      m_dat_o     <= '0;
      m_wr_o      <= 1'b0;
      m_wstrb_o   <= '0;
      m_en_o      <= '0;
      timeout_o   <= 1'b0;
      err_count_o <= '0;
    end else begin
      s_ack_o   <= 1'b0;
      timeout_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (s_en_i) begin
            m_adr_o   <= s_adr_i[LADR_W-1:0];
            m_dat_o   <= s_dat_i;
            m_wr_o    <= s_wr_i;
            m_wstrb_o <= s_wstrb_i;
            sel       <= req_sel;
            if (SLAVE_PRESENT[req_sel]) begin
              m_en_o <= NSLV'(1) << req_sel;
              state  <= ST_WAIT;
            end else begin
              state  <= ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          if (sel_ack) begin
            s_dat_o <= sel_dat;
            s_ack_o <= 1'b1;
            m_en_o  <= '0;
            state   <= ST_GAP;
          end
        end
        ST_ERR: ;
        default: begin
          // Wait for the master to release s_en_i before accepting anew.
          if (!s_en_i) begin
            state <= ST_IDLE;
          end
        end
      endcase

      if (err_take) begin
        s_dat_o   <= ERR_DATA;
        s_ack_o   <= 1'b1;
        timeout_o <= 1'b1;
        m_en_o    <= '0;
        state     <= ST_GAP;
        if (err_count_o != 8'hFF) begin
          err_count_o <= err_count_o + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_boardman_bus_splitter.sv
// Directed bench: two splitter instances (all slaves present, slave 3 absent),
// both with an 8-cycle timeout.
module tb_boardman_bus_splitter;

  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  s_adr;
  logic [31:0]  s_dat;
  logic         s_en;
  logic         s_wr;
  logic [3:0]   s_wstrb;
  logic [127:0] m_dat_i;
  logic [3:0]   m_ack_i;

  logic [31:0]  s_dat_o;
  logic         s_ack_o;
  logic [17:0]  m_adr_o;
  logic [31:0]  m_dat_o;
  logic         m_wr_o;
  logic [3:0]   m_wstrb_o;
  logic [3:0]   m_en_o;
  logic         timeout_o;
  logic [7:0]   err_count_o;

  logic         b_s_en;
  logic [31:0]  b_s_dat;
  logic         b_s_ack;
  logic [17:0]  b_m_adr;
  logic [31:0]  b_m_dat;
  logic         b_m_wr;
  logic [3:0]   b_m_wstrb;
  logic [3:0]   b_m_en;
  logic         b_timeout;
  logic [7:0]   b_err_count;

  int checks   = 0;
  int failures = 0;

  int          r_ack_at, r_ack_cnt, r_en_cnt, r_bad_en, r_to_cnt;
  logic [31:0] r_dat;
  logic [17:0] r_adr;
  logic [31:0] r_wdat;
  logic        r_wr;
  logic [3:0]  r_wstrb;

  always #5 clk = ~clk;

  boardman_bus_splitter #(
    .SEL_BITS(2), .SLAVE_PRESENT(4'b1111), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hBADACCE5)
  ) dut (
    .clk(clk), .rst(rst),
    .s_adr_i(s_adr), .s_dat_i(s_dat), .s_dat_o(s_dat_o), .s_en_i(s_en),
    .s_wr_i(s_wr), .s_wstrb_i(s_wstrb), .s_ack_o(s_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_wr_o(m_wr_o), .m_wstrb_o(m_wstrb_o),
    .m_en_o(m_en_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .timeout_o(timeout_o), .err_count_o(err_count_o)
  );

  boardman_bus_splitter #(
    .SEL_BITS(2), .SLAVE_PRESENT(4'b0111), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hBADACCE5)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_adr_i(s_adr), .s_dat_i(s_dat), .s_dat_o(b_s_dat), .s_en_i(b_s_en),
    .s_wr_i(s_wr), .s_wstrb_i(s_wstrb), .s_ack_o(b_s_ack),
    .m_adr_o(b_m_adr), .m_dat_o(b_m_dat), .m_wr_o(b_m_wr), .m_wstrb_o(b_m_wstrb),
    .m_en_o(b_m_en), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .timeout_o(b_timeout), .err_count_o(b_err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge: sample, then drive.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on dut; the selected slave acks in interval ack_at (0 = never),
  // the master keeps s_en high for hold intervals after s_ack_o.
  task automatic access(input logic [19:0] adr, input logic [31:0] wdat, input logic wr,
                        input logic [3:0] wstrb, input int ack_at, input logic [31:0] rdat,
                        input int hold);
    logic [1:0] sel;
    logic [3:0] onehot;
    int         stop;
    sel    = adr[19:18];
    onehot = 4'b0001 << sel;
    m_dat_i = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    m_dat_i[sel*32 +: 32] = rdat;
    m_ack_i = '0;
    s_adr = adr; s_dat = wdat; s_wr = wr; s_wstrb = wstrb; s_en = 1'b1;
    r_ack_at = -1; r_ack_cnt = 0; r_en_cnt = 0; r_bad_en = 0; r_to_cnt = 0;
    r_dat = '0; r_adr = '0; r_wdat = '0; r_wr = 1'b0; r_wstrb = '0;
    stop = 40;
    for (int i = 1; i <= stop; i++) begin
      step();
      if (s_ack_o) begin
        r_ack_cnt++;
        if (r_ack_at < 0) begin
          r_ack_at = i;
          r_dat    = s_dat_o;
          stop     = i + hold + 1;
        end
      end
      if (timeout_o) r_to_cnt++;
      if (m_en_o == onehot) begin
        if (r_en_cnt == 0) begin
          r_adr = m_adr_o; r_wdat = m_dat_o; r_wr = m_wr_o; r_wstrb = m_wstrb_o;
        end
        r_en_cnt++;
      end else if (m_en_o != 4'b0000) begin
        r_bad_en++;
      end
      m_ack_i = (i == ack_at) ? onehot : 4'b0000;
      if (r_ack_at >= 0 && i >= r_ack_at + hold) s_en = 1'b0;
    end
    m_ack_i = '0;
    s_en    = 1'b0;
  endtask

  task automatic idle(input int n, input logic [3:0] ack_mask, output int spur);
    spur    = 0;
    m_ack_i = ack_mask;
    repeat (n) begin
      step();
      if (s_ack_o || timeout_o || m_en_o != 4'b0000) spur++;
    end
    m_ack_i = '0;
  endtask

  task automatic access_b(output int at, output logic [31:0] dat, output int en_seen,
                          output int to_seen);
    s_adr = 20'hC0000; s_wr = 1'b0; s_wstrb = 4'h0; b_s_en = 1'b1;
    at = -1; dat = '0; en_seen = 0; to_seen = 0;
    for (int i = 1; i <= 10 && at < 0; i++) begin
      step();
      if (b_m_en != 4'b0000) en_seen++;
      if (b_timeout) to_seen++;
      if (b_s_ack) begin
        at     = i;
        dat    = b_s_dat;
        b_s_en = 1'b0;
      end
    end
    b_s_en = 1'b0;
    step();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          spur, at, en_seen, to_seen, en_total, to_total, bad_at;
    logic [31:0] dat;

    rst = 1'b1; s_en = 1'b0; b_s_en = 1'b0; s_adr = '0; s_dat = '0;
    s_wr = 1'b0; s_wstrb = '0; m_dat_i = '0; m_ack_i = '0;
    repeat (3) step();
    check("rst_s_ack", {31'd0, s_ack_o}, 32'd0);
    check("rst_m_en", {28'd0, m_en_o}, 32'd0);
    check("rst_s_dat", s_dat_o, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    check("rst_err_count", {24'd0, err_count_o}, 32'd0);
    check("rst_m_adr", {14'd0, m_adr_o}, 32'd0);
    rst = 1'b0;
    step();

    // Write to slave 1, ack three cycles into the enable.
    access(20'h40010, 32'h12345678, 1'b1, 4'hF, 3, 32'h0000_1111, 0);
    check("wr_m_adr", {14'd0, r_adr}, 32'h00010);
    check("wr_m_dat", r_wdat, 32'h12345678);
    check("wr_m_wr", {31'd0, r_wr}, 32'd1);
    check("wr_m_wstrb", {28'd0, r_wstrb}, 32'hF);
    check("wr_en_cycles", r_en_cnt, 3);
    check("wr_bad_en", r_bad_en, 0);
    check("wr_ack_at", r_ack_at, 4);
    check("wr_s_dat", r_dat, 32'h0000_1111);
    check("wr_no_timeout", r_to_cnt, 0);
    check("wr_err_count", {24'd0, err_count_o}, 32'd0);

    // Read from slave 3 with immediate ack: two-cycle round trip.
    access(20'hC0004, 32'h0, 1'b0, 4'h0, 1, 32'hDEADBEEF, 0);
    check("rd3_m_adr", {14'd0, r_adr}, 32'h00004);
    check("rd3_m_wr", {31'd0, r_wr}, 32'd0);
    check("rd3_ack_at", r_ack_at, 2);
    check("rd3_s_dat", r_dat, 32'hDEADBEEF);
    check("rd3_en_cycles", r_en_cnt, 1);

    // Slave 0, all-ones local address, partial strobes.
    access(20'h3FFFF, 32'h0F0F0F0F, 1'b1, 4'h5, 2, 32'h13579BDF, 0);
    check("s0_m_adr", {14'd0, r_adr}, 32'h3FFFF);
    check("s0_m_wstrb", {28'd0, r_wstrb}, 32'h5);
    check("s0_ack_at", r_ack_at, 3);
    check("s0_s_dat", r_dat, 32'h13579BDF);

    // Slave 2 never acks: timeout after 8 enable cycles.
    access(20'h80000, 32'h0, 1'b0, 4'h0, 0, 32'h22222222, 0);
    check("to_en_cycles", r_en_cnt, 8);
    check("to_bad_en", r_bad_en, 0);
    check("to_ack_at", r_ack_at, 9);
    check("to_s_dat", r_dat, 32'hBADACCE5);
    check("to_pulses", r_to_cnt, 1);
    check("to_err_count", {24'd0, err_count_o}, 32'd1);
    idle(3, 4'b0100, spur);
    check("late_ack_ignored", spur, 0);
    check("late_ack_s_dat", s_dat_o, 32'hBADACCE5);
    check("late_ack_err_count", {24'd0, err_count_o}, 32'd1);

    // Ack on the limit cycle wins; s_en held five cycles after the ack.
    access(20'h80020, 32'h0, 1'b0, 4'h0, 8, 32'hCAFEF00D, 5);
    check("lim_ack_at", r_ack_at, 9);
    check("lim_s_dat", r_dat, 32'hCAFEF00D);
    check("lim_no_timeout", r_to_cnt, 0);
    check("lim_en_cycles", r_en_cnt, 8);
    check("lim_single_ack", r_ack_cnt, 1);
    check("lim_err_count", {24'd0, err_count_o}, 32'd1);

    // Reset during the second WAIT cycle aborts the access.
    m_ack_i = '0; s_adr = 20'h40000; s_wr = 1'b0; s_wstrb = 4'h0; s_en = 1'b1;
    step();
    check("abort_m_en_1", {28'd0, m_en_o}, 32'b0010);
    step();
    rst = 1'b1;
    step();
    check("abort_m_en", {28'd0, m_en_o}, 32'd0);
    check("abort_s_ack", {31'd0, s_ack_o}, 32'd0);
    check("abort_err_count", {24'd0, err_count_o}, 32'd0);
    rst = 1'b0; s_en = 1'b0;
    idle(4, 4'b0000, spur);
    check("abort_quiet", spur, 0);
    access(20'h40004, 32'h0, 1'b0, 4'h0, 2, 32'h600DCAFE, 0);
    check("post_abort_ack_at", r_ack_at, 3);
    check("post_abort_s_dat", r_dat, 32'h600DCAFE);

    // Absent slave 3 on the second instance; error counter saturates at 255.
    access_b(at, dat, en_seen, to_seen);
    check("abs_ack_at", at, 2);
    check("abs_s_dat", dat, 32'hBADACCE5);
    check("abs_no_en", en_seen, 0);
    check("abs_timeout", to_seen, 1);
    check("abs_err_count_1", {24'd0, b_err_count}, 32'd1);
    en_total = 0; to_total = 0; bad_at = 0;
    for (int n = 1; n < 300; n++) begin
      access_b(at, dat, en_seen, to_seen);
      en_total += en_seen;
      to_total += to_seen;
      if (at != 2) bad_at++;
    end
    check("abs_loop_ack_at", bad_at, 0);
    check("abs_loop_no_en", en_total, 0);
    check("abs_loop_timeouts", to_total, 299);
    check("abs_err_count_sat", {24'd0, b_err_count}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
